// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_queue_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP              = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fq_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fq_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - memory, redirect and decode handshake signals of the fetch queue
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - fetch_fifo: DEPTH-entry instruction+PC buffer with clear
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  fq_entry_t                i_push_data,
  input  logic                     i_pop,
  output fq_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Entry storage; contents are only observed through the head when not empty
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC generation, fetch FSM and decode handshake; FETCH_QUEUE_BYPASS_EN adds empty-queue bypass
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master io_fq
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NXT_W = CNT_W + 1;

  fq_state_e         r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;

  fq_entry_t         w_head;
  fq_entry_t         w_push_data;
  logic [CNT_W-1:0]  w_count;
  logic [NXT_W-1:0]  w_count_next;
  logic              w_empty;
  logic              w_keep_rsp;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic              w_slot_free;
  logic              w_issue_state;
  logic              w_issue;
  logic              w_inst_valid;
  logic [INST_W-1:0] w_inst;
  logic [ADDR_W-1:0] w_inst_pc;

  // A response is kept only for a live request and never in a redirect cycle.
  assign w_keep_rsp = rst && io_fq.imem_rvalid && (r_state == S_WAIT) && !io_fq.redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_keep_rsp && w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // Queue traffic for this cycle and the resulting issue decision
  always_comb begin
    w_pop         = rst && !w_empty && io_fq.inst_ready && !io_fq.redirect;
    w_push        = w_keep_rsp && !(w_bypass && io_fq.inst_ready);
    w_push_data   = '{inst: io_fq.imem_rdata, pc: r_req_pc};
    w_count_next  = {1'b0, w_count} + NXT_W'(w_push) - NXT_W'(w_pop);
    w_slot_free   = (w_count_next < NXT_W'(DEPTH));
    w_issue_state = (r_state == S_IDLE) || ((r_state == S_WAIT) && io_fq.imem_rvalid);
    w_issue       = rst && !io_fq.redirect && w_issue_state && w_slot_free;
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (io_fq.redirect),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty)
  );

  // Decode-side view: bypassed response, else buffer head, else a NOP bubble
  always_comb begin
    w_inst_valid = 1'b0;
    w_inst       = '0;
    w_inst_pc    = '0;
    if (rst) begin
      if (w_bypass) begin
        w_inst_valid = 1'b1;
        w_inst       = io_fq.imem_rdata;
        w_inst_pc    = r_req_pc;
      end else if (!w_empty) begin
        w_inst_valid = 1'b1;
        w_inst       = w_head.inst;
        w_inst_pc    = w_head.pc;
      end else begin
        w_inst       = NOP;
      end
    end
  end

  // Fetch state machine: PC sequencing, outstanding-request tracking and redirect
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
    end else if (io_fq.redirect) begin
      r_fetch_pc <= align_pc(io_fq.redirect_pc);
      // A request still in flight must have its response swallowed later.
      if ((r_state != S_IDLE) && !io_fq.imem_rvalid) begin
        r_state <= S_DROP;
      end else begin
        r_state <= S_IDLE;
      end
    end else if (w_issue) begin
      r_req_pc   <= r_fetch_pc;
      r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      r_state    <= S_WAIT;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_IDLE;
        S_WAIT: if (io_fq.imem_rvalid) r_state <= S_IDLE;
        S_DROP: if (io_fq.imem_rvalid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_fq.imem_req   = w_issue;
  assign io_fq.imem_addr  = w_issue ? r_fetch_pc : '0;
  assign io_fq.inst_valid = w_inst_valid;
  assign io_fq.inst       = w_inst;
  assign io_fq.inst_pc    = w_inst_pc;

endmodule
